sram_1rw_arb_ctrl: RTL and testbench
====================================

SRAM_1RW_ARB_CTRL -- requirements
Module: sram_1rw_arb_ctrl

Interface
- REQ-001: Parameter width_p, default 8, data width of the single-port SRAM macro.
- REQ-002: Parameter addr_width_p, default 10, macro address width; depth is 2^addr_width_p (1024).
- REQ-003: Parameter clear_on_reset_p, default 1; 1 means zero-fill the whole macro after reset.
- REQ-004: clk_i, input, 1, sole clock; all state updates on its rising edge.
- REQ-005: reset_i, input, 1, synchronous active-high reset.
- REQ-006: v_i, input, [1:0], per-port request valid; port 0 is the core, port 1 is DMA.
- REQ-007: w_i, input, [1:0], per-port write (1) / read (0).
- REQ-008: addr_i, input, [1:0][addr_width_p-1:0], per-port address.
- REQ-009: data_i, input, [1:0][width_p-1:0], per-port write data.
- REQ-010: ready_o, output, [1:0], per-port grant; a request transfers when v_i[n] & ready_o[n].
- REQ-011: data_v_o, output, [1:0], per-port read-data valid.
- REQ-012: data_o, output, [width_p-1:0], read data shared by both ports, qualified by data_v_o.
- REQ-013: init_done_o, output, 1, high once the clear sequence completes.
- REQ-014: mem_cen_o, mem_gwen_o, output, 1 each, active-low macro chip enable and global write enable.
- REQ-015: mem_wen_o, output, [width_p-1:0], active-low macro bit write enables.
- REQ-016: mem_a_o, output, [addr_width_p-1:0]; mem_d_o, output, [width_p-1:0]; macro address and write data.
- REQ-017: mem_q_i, input, [width_p-1:0], macro read data, valid the cycle after a read access.

Function
- REQ-018: The FSM SHALL have exactly two states: CLEAR and RUN.
- REQ-019: In CLEAR, the block SHALL hold ready_o=0 and, on each cycle, write 0 to the macro at address clr_cnt, with clr_cnt counting 0..2^addr_width_p-1.
- REQ-020: The block SHALL leave CLEAR the cycle after the write to the last address; init_done_o SHALL be 1 from that cycle on and stay 1 until reset.
- REQ-021: With clear_on_reset_p=0, the block SHALL enter RUN, with init_done_o=1, on the first cycle after reset deasserts.
- REQ-022: In RUN, at most one request is granted per cycle; ready_o SHALL be combinational from v_i and the round-robin pointer.
- REQ-023: Round-robin: a single valid port SHALL be granted; when both are valid, the port not granted last SHALL win; the pointer SHALL update only on a transfer.
- REQ-024: On a transfer, mem_cen_o=0, mem_a_o=addr_i[g] and mem_d_o=data_i[g] in the same cycle; on a write, mem_gwen_o=0 and mem_wen_o=all 0; otherwise mem_gwen_o=1 and mem_wen_o=all 1.
- REQ-025: With no transfer and not in CLEAR, mem_cen_o=1 and mem_gwen_o=1.
- REQ-026: For a granted read, data_v_o[g] SHALL be 1 exactly one cycle later with data_o=mem_q_i; reads have 1-cycle latency and no backpressure.
- REQ-027: Writes SHALL produce no data_v_o pulse.
- REQ-028: Back-to-back transfers on every cycle SHALL be supported; a read that follows a write to the same address SHALL return the new data.

Reset
- REQ-029: While reset_i=1: ready_o=0, data_v_o=0, mem_cen_o=1, mem_gwen_o=1, mem_wen_o=all 1, init_done_o=0, the pointer favours port 0, clr_cnt=0.
- REQ-030: Reset asserted mid-CLEAR or mid-RUN SHALL restart the block from CLEAR (or RUN if clear_on_reset_p=0); an in-flight data_v_o SHALL be suppressed.

Verification
- REQ-031: Reset, then idle -> exactly 1024 consecutive writes of 0 on addresses 0..1023; init_done_o rises the following cycle; a read of 0x3FF returns 0x00.
- REQ-032: Port 0 writes 0xA5 to 0x010, then reads 0x010 -> data_v_o=2'b01 one cycle after the read grant, with data_o=0xA5.
- REQ-033: Both ports hold read requests for 4 cycles -> grants alternate 0,1,0,1, and each data_v_o pulse lands on the matching port.
- REQ-034: Port 1 read in flight while reset_i pulses for 1 cycle -> no data_v_o; CLEAR restarts at address 0.
- REQ-035: v_i=2'b11 during CLEAR -> ready_o stays 0 until init_done_o=1, then port 0 is granted first.

Source files
------------

// File: rtl/sram_1rw_arb_ctrl.sv
// Two-port round-robin front end for a 1RW SRAM macro.
// It zero-fills the macro after reset, then grants one core or DMA request per cycle.
module sram_1rw_arb_ctrl #(
  parameter int width_p          = 8,
  parameter int addr_width_p     = 10,
  parameter int clear_on_reset_p = 1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [1:0]                   v_i,
  input  logic [1:0]                   w_i,
  input  logic [1:0][addr_width_p-1:0] addr_i,
  input  logic [1:0][width_p-1:0]      data_i,
  output logic [1:0]                   ready_o,
  output logic [1:0]                   data_v_o,
  output logic [width_p-1:0]           data_o,
  output logic                         init_done_o,
  output logic                         mem_cen_o,
  output logic                         mem_gwen_o,
  output logic [width_p-1:0]           mem_wen_o,
  output logic [addr_width_p-1:0]      mem_a_o,
  output logic [width_p-1:0]           mem_d_o,
  input  logic [width_p-1:0]           mem_q_i
);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t                  r_state;
  logic [addr_width_p-1:0] r_clr_cnt;
  logic                    r_init_done;
  logic                    r_ptr;
  logic [1:0]              r_data_v;

  logic       w_run;
  logic       w_clr;
  logic [1:0] w_gnt;
  logic       w_xfer;
  logic       w_sel;
  logic       w_wr;

  assign w_run = (r_state == S_RUN) & ~reset_i;
  assign w_clr = (r_state == S_CLEAR) & ~reset_i;

  // r_ptr names the port that wins when both are valid
  always_comb begin
    w_gnt = 2'b00;
    if (w_run) begin
      if (v_i == 2'b11) w_gnt = r_ptr ? 2'b10 : 2'b01;
      else              w_gnt = v_i;
    end
  end

  assign w_xfer = |w_gnt;
  assign w_sel  = w_gnt[1];
  assign w_wr   = w_i[w_sel];

  assign ready_o     = w_gnt;
  assign data_v_o    = r_data_v & {2{~reset_i}};
  assign data_o      = mem_q_i;
  assign init_done_o = r_init_done & ~reset_i;

  always_comb begin
    mem_cen_o  = 1'b1;
    mem_gwen_o = 1'b1;
    mem_wen_o  = '1;
    mem_a_o    = '0;
    mem_d_o    = '0;
    unique case (1'b1)
      w_clr: begin
        mem_cen_o  = 1'b0;
        mem_gwen_o = 1'b0;
        mem_wen_o  = '0;
        mem_a_o    = r_clr_cnt;
      end
      w_xfer: begin
        mem_cen_o = 1'b0;
        mem_a_o   = addr_i[w_sel];
        mem_d_o   = data_i[w_sel];
        if (w_wr) begin
          mem_gwen_o = 1'b0;
          mem_wen_o  = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= (clear_on_reset_p != 0) ? S_CLEAR : S_RUN;
      r_clr_cnt   <= '0;
      r_init_done <= (clear_on_reset_p == 0);
      r_ptr       <= 1'b0;
      r_data_v    <= 2'b00;
    end else begin
      r_data_v <= w_gnt & {2{~w_wr}};
      if (w_xfer) r_ptr <= ~w_sel;
      unique case (r_state)
        S_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (&r_clr_cnt) begin
            r_state     <= S_RUN;
            r_init_done <= 1'b1;
          end
        end
        S_RUN: ;
        default: r_state <= S_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_1rw_arb_ctrl.sv
// Directed bench for sram_1rw_arb_ctrl.
// It drives the controller against a behavioural 1RW SRAM model.
module tb_sram_1rw_arb_ctrl;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic [1:0]       v_i;
  logic [1:0]       w_i;
  logic [1:0][9:0]  addr_i;
  logic [1:0][7:0]  data_i;
  logic [1:0]       ready_o;
  logic [1:0]       data_v_o;
  logic [7:0]       data_o;
  logic             init_done_o;
  logic             mem_cen_o;
  logic             mem_gwen_o;
  logic [7:0]       mem_wen_o;
  logic [9:0]       mem_a_o;
  logic [7:0]       mem_d_o;
  logic [7:0]       mem_q_i;

  int n_chk  = 0;
  int n_fail = 0;

  sram_1rw_arb_ctrl dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .v_i         (v_i),
    .w_i         (w_i),
    .addr_i      (addr_i),
    .data_i      (data_i),
    .ready_o     (ready_o),
    .data_v_o    (data_v_o),
    .data_o      (data_o),
    .init_done_o (init_done_o),
    .mem_cen_o   (mem_cen_o),
    .mem_gwen_o  (mem_gwen_o),
    .mem_wen_o   (mem_wen_o),
    .mem_a_o     (mem_a_o),
    .mem_d_o     (mem_d_o),
    .mem_q_i     (mem_q_i)
  );

  always #5 clk_i = ~clk_i;

  // Macro model; starts as X so a zero readback shows the clear happened
  logic [7:0] mem [1024];
  always @(posedge clk_i) begin
    if (!mem_cen_o) begin
      if (!mem_gwen_o)
        mem[mem_a_o] <= (mem[mem_a_o] & mem_wen_o) | (mem_d_o & ~mem_wen_o);
      else
        mem_q_i <= mem[mem_a_o];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  initial begin
    int errs;
    logic [1:0] rdy_exp;
    logic [1:0] dv_exp;
    logic [7:0] do_exp;
    reset_i = 1'b1;
    v_i     = 2'b11;
    w_i     = 2'b00;
    addr_i  = '0;
    data_i  = '0;
    addr_i[0] = 10'h3FF;
    addr_i[1] = 10'h3FF;
    step(); step();
    #1;
    chk("rst_ready", ready_o, 2'b00);
    chk("rst_dv", data_v_o, 2'b00);
    chk("rst_cen", mem_cen_o, 1'b1);
    chk("rst_gwen", mem_gwen_o, 1'b1);
    chk("rst_wen", mem_wen_o, 8'hFF);
    chk("rst_init", init_done_o, 1'b0);

    // Clear sequence with both ports requesting throughout
    step();
    reset_i = 1'b0;
    #1;
    errs = 0;
    for (int i = 0; i < 1024; i++) begin
      if (mem_cen_o !== 1'b0 || mem_gwen_o !== 1'b0 ||
          mem_wen_o !== 8'h00 || mem_a_o !== 10'(i) ||
          mem_d_o !== 8'h00 || ready_o !== 2'b00 ||
          init_done_o !== 1'b0)
        errs++;
      step();
      #1;
    end
    chk("clear_seq", errs, 0);
    chk("init_rise", init_done_o, 1'b1);
    chk("first_gnt", ready_o, 2'b01);
    chk("rd3ff_a", mem_a_o, 10'h3FF);
    chk("rd3ff_cen", mem_cen_o, 1'b0);
    chk("rd3ff_gwen", mem_gwen_o, 1'b1);

    step();
    v_i = 2'b00;
    #1;
    chk("rd3ff_dv", data_v_o, 2'b01);
    chk("rd3ff_q", data_o, 8'h00);
    chk("idle_ready", ready_o, 2'b00);
    chk("idle_cen", mem_cen_o, 1'b1);
    chk("idle_gwen", mem_gwen_o, 1'b1);

    // Port 0 write then read of the same address
    step();
    v_i = 2'b01; w_i = 2'b01;
    addr_i[0] = 10'h010; data_i[0] = 8'hA5;
    #1;
    chk("wr_ready", ready_o, 2'b01);
    chk("wr_cen", mem_cen_o, 1'b0);
    chk("wr_gwen", mem_gwen_o, 1'b0);
    chk("wr_wen", mem_wen_o, 8'h00);
    chk("wr_a", mem_a_o, 10'h010);
    chk("wr_d", mem_d_o, 8'hA5);
    step();
    w_i = 2'b00;
    #1;
    chk("rd_ready", ready_o, 2'b01);
    chk("rd_gwen", mem_gwen_o, 1'b1);
    chk("rd_wen", mem_wen_o, 8'hFF);
    chk("wr_no_dv", data_v_o, 2'b00);
    step();
    v_i = 2'b00;
    #1;
    chk("rd_dv", data_v_o, 2'b01);
    chk("rd_q", data_o, 8'hA5);

    // Port 1 write; pointer then favours port 0 again
    step();
    v_i = 2'b10; w_i = 2'b10;
    addr_i[1] = 10'h020; data_i[1] = 8'h5C;
    #1;
    chk("p1wr_ready", ready_o, 2'b10);
    chk("p1wr_gwen", mem_gwen_o, 1'b0);
    chk("p1wr_a", mem_a_o, 10'h020);
    chk("p1wr_d", mem_d_o, 8'h5C);

    // Both ports read for 4 cycles: grants 0,1,0,1
    step();
    v_i = 2'b11; w_i = 2'b00;
    #1;
    chk("rr0_ready", ready_o, 2'b01);
    chk("rr0_a", mem_a_o, 10'h010);
    chk("rr0_dv", data_v_o, 2'b00);
    for (int k = 1; k < 4; k++) begin
      step();
      #1;
      rdy_exp = (k % 2) ? 2'b10 : 2'b01;
      dv_exp  = (k % 2) ? 2'b01 : 2'b10;
      do_exp  = (k % 2) ? 8'hA5 : 8'h5C;
      chk($sformatf("rr%0d_ready", k), ready_o, rdy_exp);
      chk($sformatf("rr%0d_a", k), mem_a_o,
          (k % 2) ? 10'h020 : 10'h010);
      chk($sformatf("rr%0d_dv", k), data_v_o, dv_exp);
      chk($sformatf("rr%0d_q", k), data_o, do_exp);
    end
    step();
    v_i = 2'b00;
    #1;
    chk("rr4_dv", data_v_o, 2'b10);
    chk("rr4_q", data_o, 8'h5C);

    // Port 1 read in flight when reset pulses
    step();
    v_i = 2'b10; w_i = 2'b00;
    #1;
    chk("fl_ready", ready_o, 2'b10);
    step();
    v_i = 2'b00; reset_i = 1'b1;
    #1;
    chk("fl_dv_rst", data_v_o, 2'b00);
    chk("fl_cen_rst", mem_cen_o, 1'b1);
    chk("fl_init_rst", init_done_o, 1'b0);
    step();
    reset_i = 1'b0;
    #1;
    chk("fl_dv_after", data_v_o, 2'b00);
    chk("reclr_a0", mem_a_o, 10'h000);
    chk("reclr_cen", mem_cen_o, 1'b0);
    chk("reclr_gwen", mem_gwen_o, 1'b0);
    chk("reclr_init", init_done_o, 1'b0);
    step();
    #1;
    chk("reclr_a1", mem_a_o, 10'h001);
    chk("reclr_dv", data_v_o, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
